bsg_adder_carry_save_resolve: RTL and testbench
===============================================

// Module: bsg_adder_carry_save_resolve
//
// PURPOSE
// - Downstream stage of the carry-save Wallace-tree adders.
//   Takes the redundant (A,B) pair and resolves it into one binary sum with a multi-cycle
//   chunked ripple carry-propagate adder.
// - Uses chunk_width_p bits per cycle, so a wide final add never sets the critical path.
// - Input side is valid/ready; output side is valid/yumi.
//
// PARAMETERS
// - width_p        35   operand/sum width; equals the tree output width, e.g. 32 + clog2(8).
// - chunk_width_p  16   bits resolved per cycle, >= 1.
// - num_chunks_lp  (derived) ceil(width_p / chunk_width_p).
//
// PORTS
// - clk_i      in   1        clock, rising edge.
// - reset_n_i  in   1        reset; asynchronous assert, active-low.
// - v_i        in   1        the a_i/b_i pair is valid.
// - ready_o    out  1        block can accept a pair this cycle.
// - a_i        in   width_p  carry-save operand A (tree resA).
// - b_i        in   width_p  carry-save operand B (tree resB).
// - v_o        out  1        sum_o/carry_o are valid.
// - yumi_i     in   1        consumer takes the result; legal only when v_o=1.
// - sum_o      out  width_p  (a + b) mod 2^width_p.
// - carry_o    out  1        carry out of bit width_p-1.
//
// BEHAVIOUR
// - Reset (reset_n_i=0, asynchronous):
//   - state=IDLE; operand, sum, carry and chunk-counter registers all cleared.
//   - Outputs: v_o=0, sum_o=0, carry_o=0.
//   - ready_o is forced 0 while reset_n_i=0 and becomes 1 in the first cycle after release.
//   - Reset mid-operation aborts it; the partial result is discarded and never presented.
// - FSM states: IDLE, BUSY, DONE.
// - IDLE:
//   - ready_o=1, v_o=0.
//   - On v_i & ready_o: capture a_i and b_i, set cnt=0, clear the running carry, go to BUSY.
//   - a_i/b_i need not be held after the accepting edge.
// - BUSY:
//   - ready_o=0, v_o=0.
//   - Each cycle computes {c, s} = A[cnt] + B[cnt] + carry over chunk cnt.
//   - Writes s into sum chunk cnt, stores c as the new carry, then cnt++.
//   - Top chunk width = width_p - (num_chunks_lp-1)*chunk_width_p; its carry-out becomes carry_o.
//   - Goes to DONE after chunk num_chunks_lp-1.
// - DONE:
//   - v_o=1, ready_o=0.
//   - sum_o/carry_o are held stable until yumi_i.
//   - On yumi_i go to IDLE. There is no same-cycle accept; the next pair is taken in IDLE.
// - Latency:
//   - v_o rises exactly num_chunks_lp cycles after the accepting edge.
//   - Minimum issue period is num_chunks_lp+2 cycles.
// - chunk_width_p >= width_p gives num_chunks_lp=1: one BUSY cycle.
// - sum_o and carry_o are registered outputs; they change only on BUSY cycles or at reset.
//   Values outside DONE are don't-care to the consumer.
// - yumi_i while v_o=0: ignored, and flagged by a simulation assertion.
// - v_i while ready_o=0: ignored; upstream holds the pair until ready_o.
// - Arithmetic is unsigned. The tree sizes width_p so that the true sum fits, so carry_o=1
//   flags an upstream overflow or a signed wrap; the block does not treat it as an error.
//
// TESTING
// 1. Defaults, a=35'h7_FFFF_FFFF, b=1:
//    sum_o=0, carry_o=1, v_o high 3 cycles after accept.
// 2. Defaults, a=35'h0_0000_FFFF, b=1:
//    sum_o=35'h0_0001_0000, carry_o=0 (carry crosses chunk 0->1).
// 3. Back-pressure: yumi_i held 0 for 5 cycles in DONE, v_i=1 throughout:
//    v_o, sum_o and carry_o stay stable, ready_o=0, and no second capture.
// 4. reset_n_i pulsed low during BUSY cycle 2:
//    v_o=0 immediately; ready_o=1 after release; the next pair 5+7 gives sum_o=12.
// 5. width_p=8, chunk_width_p=16, a=8'hF0, b=8'h20:
//    sum_o=8'h10, carry_o=1, v_o high 1 cycle after accept.
// 6. Random back-to-back pairs with random yumi_i delay and width_p in {8,35,37}:
//    every result equals a+b from the model, and the issue period is >= num_chunks_lp+2.

Source files
------------

// File: rtl/bsg_adder_carry_save_resolve.sv
// Resolves a carry-save (A,B) pair into one binary sum with a chunked ripple adder,
// chunk_width_p bits per cycle; valid/ready input handshake, valid/yumi output handshake.
module bsg_adder_carry_save_resolve #(
  parameter int width_p       = 35,
  parameter int chunk_width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  output logic               v_o,
  input  logic               yumi_i,
  output logic [width_p-1:0] sum_o,
  output logic               carry_o
);

  localparam int num_chunks_lp = (width_p + chunk_width_p - 1) / chunk_width_p;
  localparam int padW          = num_chunks_lp * chunk_width_p;
  localparam int topW          = width_p - (num_chunks_lp - 1) * chunk_width_p;
  localparam int cntW          = (num_chunks_lp > 1) ? $clog2(num_chunks_lp) : 1;
  localparam logic [cntW-1:0] lastCnt = cntW'(num_chunks_lp - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e                                     state;
  logic [width_p-1:0]                         aQ, bQ;
  logic [cntW-1:0]                            cnt;
  logic                                       carryQ;
  logic                                       carryOutQ;
  logic [num_chunks_lp-1:0][chunk_width_p-1:0] aCh, bCh;
  logic [chunk_width_p:0]                     chunkSum;
  logic                                       lastChunk;

  // Operands are zero-padded to whole chunks, so the top chunk's carry-out
  // shows up at bit topW of the chunk sum rather than at bit chunk_width_p.
  assign aCh       = padW'(aQ);
  assign bCh       = padW'(bQ);
  assign chunkSum  = {1'b0, aCh[cnt]} + {1'b0, bCh[cnt]} + (chunk_width_p+1)'(carryQ);
  assign lastChunk = (cnt == lastCnt);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= IDLE;
      aQ        <= '0;
      bQ        <= '0;
      cnt       <= '0;
      carryQ    <= 1'b0;
      carryOutQ <= 1'b0;
    end else begin
      case (state)
        IDLE: if (v_i) begin
          aQ     <= a_i;
          bQ     <= b_i;
          cnt    <= '0;
          carryQ <= 1'b0;
          state  <= BUSY;
        end
        BUSY: begin
          carryQ <= chunkSum[chunk_width_p];
          cnt    <= cnt + cntW'(1);
          if (lastChunk) begin
            carryOutQ <= chunkSum[topW];
            state     <= DONE;
          end
        end
        DONE: if (yumi_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < num_chunks_lp; k++) begin : gChunk
    localparam int w = (k == num_chunks_lp - 1) ? topW : chunk_width_p;
    logic [w-1:0] q;
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)                             q <= '0;
      else if (state == BUSY && cnt == cntW'(k))  q <= chunkSum[w-1:0];
    end
    assign sum_o[k*chunk_width_p +: w] = q;
  end

  assign carry_o = carryOutQ;
  assign v_o     = (state == DONE);
  assign ready_o = reset_n_i && (state == IDLE);

`ifndef SYNTHESIS
  always @(posedge clk_i)
    if (reset_n_i) assert (!yumi_i || v_o) else $error("yumi_i asserted while v_o=0");
`endif

endmodule

// File: tb/tb_bsg_adder_carry_save_resolve.sv
// Bench for bsg_adder_carry_save_resolve: three widths checked every cycle against
// a pending-result model of a+b, plus directed literal cases.
module tb_bsg_adder_carry_save_resolve;

  localparam int W  [3] = '{35, 8, 37};
  localparam int NC [3] = '{3, 1, 5};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] v = '0, yumi = '0;
  logic [2:0] rdy, vo, co;
  logic [2:0][36:0] a = '0, b = '0;
  logic [34:0] s0;
  logic [7:0]  s1;
  logic [36:0] s2;

  int nCmp = 0, nBad = 0, cyc = 0;

  always #5 clk = ~clk;

  bsg_adder_carry_save_resolve #(.width_p(35), .chunk_width_p(16)) dut0 (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v[0]), .ready_o(rdy[0]), .a_i(a[0][34:0]),
    .b_i(b[0][34:0]), .v_o(vo[0]), .yumi_i(yumi[0]), .sum_o(s0), .carry_o(co[0]));
  bsg_adder_carry_save_resolve #(.width_p(8), .chunk_width_p(16)) dut1 (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v[1]), .ready_o(rdy[1]), .a_i(a[1][7:0]),
    .b_i(b[1][7:0]), .v_o(vo[1]), .yumi_i(yumi[1]), .sum_o(s1), .carry_o(co[1]));
  bsg_adder_carry_save_resolve #(.width_p(37), .chunk_width_p(8)) dut2 (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v[2]), .ready_o(rdy[2]), .a_i(a[2]),
    .b_i(b[2]), .v_o(vo[2]), .yumi_i(yumi[2]), .sum_o(s2), .carry_o(co[2]));

  function automatic logic [36:0] sumOf(int d);
    case (d)
      0:       return {2'b0, s0};
      1:       return {29'b0, s1};
      default: return s2;
    endcase
  endfunction

  function automatic logic [63:0] maskOf(int d);
    return (64'd1 << W[d]) - 64'd1;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(string nm);
    nCmp++;
    nBad++;
    $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Model: at most one result outstanding per block; it is a+b, visible
  // num_chunks cycles after the accepting edge, until the consumer takes it.
  logic        pend [3] = '{0, 0, 0};
  logic [36:0] expS [3];
  logic        expC [3];
  int          accE [3] = '{-1000, -1000, -1000};

  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        chk("reset ready_o", rdy[d], 0);
        chk("reset v_o", vo[d], 0);
        chk("reset sum_o", sumOf(d), 0);
        chk("reset carry_o", co[d], 0);
        pend[d] = 1'b0;
        accE[d] = -1000;
      end else begin
        chk("ready_o", rdy[d], !pend[d]);
        chk("v_o", vo[d], pend[d] && (cyc - accE[d] >= NC[d]));
        if (vo[d] && pend[d]) begin
          chk("sum_o", sumOf(d), expS[d]);
          chk("carry_o", co[d], expC[d]);
        end
        if (v[d] && rdy[d]) begin
          logic [63:0] full;
          chk("issue period ok", (cyc + 1 - accE[d]) >= NC[d] + 2, 1);
          full    = (64'(a[d]) & maskOf(d)) + (64'(b[d]) & maskOf(d));
          expS[d] = 37'(full & maskOf(d));
          expC[d] = full[W[d]];
          pend[d] = 1'b1;
          accE[d] = cyc + 1;
        end
        if (vo[d] && yumi[d]) pend[d] = 1'b0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge, v left high.
  task automatic send(int d, logic [36:0] x, logic [36:0] y);
    int t;
    v[d] = 1'b1;
    a[d] = x;
    b[d] = y;
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (rdy[d]) break;
    end
    if (t == 200) timeout("accept");
    @(posedge clk);
    #1;
  endtask

  task automatic getRes(int d, output logic [36:0] s, output logic c);
    int t;
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (vo[d]) break;
    end
    if (t == 200) timeout("result");
    s = sumOf(d);
    c = co[d];
    @(posedge clk); #1 yumi[d] = 1'b1;
    @(posedge clk); #1 yumi[d] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [36:0] s;
    logic        c;
    int          t;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    send(0, 37'h7_FFFF_FFFF, 37'd1); v[0] = 1'b0;
    getRes(0, s, c);
    chk("all-ones+1 sum", s, 0);
    chk("all-ones+1 carry", c, 1);

    send(0, 37'h0_0000_FFFF, 37'd1); v[0] = 1'b0;
    getRes(0, s, c);
    chk("chunk-carry sum", s, 37'h0_0001_0000);
    chk("chunk-carry carry", c, 0);

    // Back-pressure: a second pair waits on v_i while the first sits in DONE.
    send(0, 37'h1234, 37'h5678);
    a[0] = 37'd1;
    b[0] = 37'd2;
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (vo[0]) break;
    end
    if (t == 200) timeout("bp result");
    repeat (5) begin
      @(negedge clk);
      chk("bp v_o", vo[0], 1);
      chk("bp ready_o", rdy[0], 0);
      chk("bp sum", sumOf(0), 37'h68AC);
      chk("bp carry", co[0], 0);
    end
    @(posedge clk); #1 yumi[0] = 1'b1;
    @(posedge clk); #1 yumi[0] = 1'b0;
    send(0, 37'd1, 37'd2); v[0] = 1'b0;
    getRes(0, s, c);
    chk("bp second sum", s, 3);

    // Reset pulse during the second BUSY cycle aborts the operation.
    send(0, 37'h3_0000_0000, 37'h1_2345_6789); v[0] = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1 chk("abort v_o", vo[0], 0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, 37'd5, 37'd7); v[0] = 1'b0;
    getRes(0, s, c);
    chk("after reset sum", s, 12);
    chk("after reset carry", c, 0);

    send(1, 37'hF0, 37'h20); v[1] = 1'b0;
    getRes(1, s, c);
    chk("w8 sum", s, 37'h10);
    chk("w8 carry", c, 1);

    for (int d = 0; d < 3; d++) begin
      fork
        begin
          for (int i = 0; i < 16; i++) begin
            logic [63:0] x, y;
            x = {$urandom, $urandom} & maskOf(d);
            y = {$urandom, $urandom} & maskOf(d);
            if (i % 5 == 0) x = maskOf(d);
            send(d, 37'(x), 37'(y));
          end
          v[d] = 1'b0;
        end
        begin
          for (int i = 0; i < 16; i++) begin
            int k;
            for (k = 0; k < 300; k++) begin
              @(negedge clk);
              if (vo[d]) break;
            end
            if (k == 300) timeout("random result");
            repeat ($urandom_range(0, 3)) @(negedge clk);
            @(posedge clk); #1 yumi[d] = 1'b1;
            @(posedge clk); #1 yumi[d] = 1'b0;
          end
        end
      join
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
